// File: rtl/nbout_psum_buffer_pkg.sv
// -----------------------------------------------------------------------------
// nbout_psum_buffer_pkg
// Shared definitions for the NBout partial-sum buffer:
//   - FSM state encoding (IDLE / ACCUM / DRAIN)
//   - cluster op-select constants (OP_SUM / OP_MAX)
//   - default lane geometry and entry width (ENTRY_W = Tn*N)
//   - INIT_BIT: replicated to form the first-pass partial sum. Zero is the
//     identity for both sum and unsigned max.
//   - idx_width(): index width that stays >= 1 for DEPTH == 1
// -----------------------------------------------------------------------------
package nbout_psum_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic OP_SUM = 1'b0;
  localparam logic OP_MAX = 1'b1;

  localparam int DEF_N   = 16;
  localparam int DEF_TN  = 16;
  localparam int ENTRY_W = DEF_N * DEF_TN;

  localparam logic INIT_BIT = 1'b0;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nbout_psum_buffer_if.sv
// -----------------------------------------------------------------------------
// nbout_psum_buffer_if
// Drain bus from the partial-sum buffer to the output writer.
//   out_valid  : finished entry on out_data/out_idx is valid
//   out_ready  : writer accepts the current beat
//   out_data   : finished entry (ENTRY_W bits)
//   out_idx    : entry index of out_data
// Modports: master = buffer (drives data), slave = writer (drives ready).
// -----------------------------------------------------------------------------
interface nbout_psum_buffer_if #(
  parameter int ENTRY_W = nbout_psum_buffer_pkg::ENTRY_W,
  parameter int IDX_W   = 2
);
  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_data;
  logic [IDX_W-1:0]   out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/nbout_step_delay.sv
// -----------------------------------------------------------------------------
// nbout_step_delay
// LAT-stage shift register that tracks each issued step until the cluster's
// result for it is available. Each stage carries {valid, idx, first, last}.
// Ports:
//   clk, rst                   clock, synchronous active-high reset (clears all stages)
//   i_valid/i_idx/i_first/i_last   step descriptor entering the pipe
//   o_valid/o_idx/o_first/o_last   descriptor at the pipe head (LAT cycles later)
// -----------------------------------------------------------------------------
module nbout_step_delay #(
  parameter int LAT   = 1,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_first,
  input  logic             i_last,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_first,
  output logic             o_last
);
  localparam int SW = IDX_W + 3;

  logic [SW-1:0] w_in;
  assign w_in = {i_valid, i_idx, i_first, i_last};

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      logic [SW-1:0] r_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) r_q <= '0;
          else     r_q <= w_in;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) r_q <= '0;
          else     r_q <= g_stage[gi-1].r_q;
        end
      end
    end
  endgenerate

  assign {o_valid, o_idx, o_first, o_last} = g_stage[LAT-1].r_q;

endmodule

// File: rtl/nbout_psum_buffer.sv
// -----------------------------------------------------------------------------
// nbout_psum_buffer
// Output-neuron partial-sum buffer (NBout) sitting after the Tn-lane sum/max
// cluster. Holds DEPTH entries of Tn x N bits, feeds the stored partial sum
// back to the cluster, captures the cluster result each step and, after the
// last input chunk, drains all entries to the writer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_start         begin a tile (IDLE only); i_iters = chunks (0 -> 1); i_op 0=sum 1=max
//   i_step          cluster consumed i_vals for the current entry this cycle
//   o_partial_sum   partial sum to the cluster, aligned with its final add/max
//   o_op            latched op select for the cluster
//   i_res           cluster result
//   o_drain         drain bus (master): valid/ready/data/idx
//   o_busy          high in ACCUM or DRAIN
//   o_done          one-cycle pulse after the last drain beat
// Optional feature: NBOUT_RELU_EN -- in DRAIN with op==sum, negative lanes
// (signed two's complement) are output as zero; buffer contents untouched.
// -----------------------------------------------------------------------------
module nbout_psum_buffer
  import nbout_psum_buffer_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int Tn    = DEF_TN,
  parameter int DEPTH = 4,
  parameter int LAT   = 1,
  parameter int ITW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [ITW-1:0]       i_iters,
  input  logic                 i_op,
  input  logic                 i_step,
  output logic [Tn*N-1:0]      o_partial_sum,
  output logic                 o_op,
  input  logic [Tn*N-1:0]      i_res,
  nbout_psum_buffer_if.master  o_drain,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int EW    = Tn * N;
  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           r_state;
  logic             r_op;
  logic [ITW-1:0]   r_iters;
  logic [ITW-1:0]   r_iter;
  logic [IDX_W-1:0] r_rd_ptr;
  logic [IDX_W-1:0] r_drain_ptr;
  logic             r_issue_done;
  logic             r_done;

  logic [EW-1:0]    r_buf [DEPTH];

  logic             w_issue;
  logic             w_first;
  logic             w_last;
  logic             w_hd_valid;
  logic [IDX_W-1:0] w_hd_idx;
  logic             w_hd_first;
  logic             w_hd_last;
  logic             w_wr_en;
  logic [EW-1:0]    w_rd_data;
  logic [EW-1:0]    w_out_data;

  // Issue side: steps only count while accumulating and before the final step.
  assign w_issue = (r_state == ST_ACCUM) && i_step && !r_issue_done;
  assign w_first = (r_iter == '0);
  assign w_last  = (r_iter == r_iters - ITW'(1)) && (r_rd_ptr == LAST_IDX);

  nbout_step_delay #(
    .LAT   (LAT),
    .IDX_W (IDX_W)
  ) u_step_delay (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_issue),
    .i_idx   (r_rd_ptr),
    .i_first (w_first),
    .i_last  (w_last),
    .o_valid (w_hd_valid),
    .o_idx   (w_hd_idx),
    .o_first (w_hd_first),
    .o_last  (w_hd_last)
  );

  // Stage-out: read and write of buf[hd_idx] happen in the same cycle, so the
  // combinational read always sees the value from the previous pass.
  assign w_wr_en = w_hd_valid && (r_state == ST_ACCUM);

  assign o_partial_sum = !w_wr_en   ? '0 :
                         w_hd_first ? {EW{INIT_BIT}} :
                                      r_buf[w_hd_idx];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_hd_idx] <= i_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_SUM;
      r_iters      <= '0;
      r_iter       <= '0;
      r_rd_ptr     <= '0;
      r_drain_ptr  <= '0;
      r_issue_done <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state      <= ST_ACCUM;
            r_op         <= i_op;
            r_iters      <= (i_iters == '0) ? ITW'(1) : i_iters;
            r_iter       <= '0;
            r_rd_ptr     <= '0;
            r_issue_done <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (w_issue) begin
            if (w_last) r_issue_done <= 1'b1;
            if (r_rd_ptr == LAST_IDX) begin
              r_rd_ptr <= '0;
              r_iter   <= r_iter + ITW'(1);
            end else begin
              r_rd_ptr <= r_rd_ptr + IDX_W'(1);
            end
          end
          // The final write lands at this edge; draining starts next cycle.
          if (w_wr_en && w_hd_last) begin
            r_state     <= ST_DRAIN;
            r_drain_ptr <= '0;
          end
        end
        ST_DRAIN: begin
          if (o_drain.out_ready) begin
            if (r_drain_ptr == LAST_IDX) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_drain_ptr <= r_drain_ptr + IDX_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_rd_data = r_buf[r_drain_ptr];

`ifdef NBOUT_RELU_EN
  genvar gi;
  generate
    for (gi = 0; gi < Tn; gi++) begin : g_relu
      assign w_out_data[gi*N +: N] =
        ((r_op == OP_SUM) && w_rd_data[gi*N + N - 1]) ? '0 : w_rd_data[gi*N +: N];
    end
  endgenerate
`else
  assign w_out_data = w_rd_data;
`endif

  assign o_drain.out_valid = (r_state == ST_DRAIN);
  assign o_drain.out_data  = w_out_data;
  assign o_drain.out_idx   = r_drain_ptr;

  assign o_op   = r_op;
  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;

endmodule

// File: tb/tb_nbout_psum_buffer.sv
module tb_nbout_psum_buffer;
  localparam int N     = 16;
  localparam int TN    = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int ITW   = 8;
  localparam int EW    = N * TN;
  localparam int IDX_W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_start;
  logic [ITW-1:0] i_iters;
  logic           i_op;
  logic           i_step;
  logic [EW-1:0]  o_partial_sum;
  logic           o_op;
  logic [EW-1:0]  i_res;
  logic           o_busy;
  logic           o_done;

  nbout_psum_buffer_if #(.ENTRY_W(EW), .IDX_W(IDX_W)) drain_if ();

  nbout_psum_buffer #(
    .N(N), .Tn(TN), .DEPTH(DEPTH), .LAT(LAT), .ITW(ITW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_iters       (i_iters),
    .i_op          (i_op),
    .i_step        (i_step),
    .o_partial_sum (o_partial_sum),
    .o_op          (o_op),
    .i_res         (i_res),
    .o_drain       (drain_if),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] model [DEPTH];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] fill(input logic [N-1:0] v);
    logic [EW-1:0] r;
    for (int k = 0; k < TN; k++) r[k*N +: N] = v;
    return r;
  endfunction

  function automatic logic [EW-1:0] lanes_inc();
    logic [EW-1:0] r;
    for (int k = 0; k < TN; k++) r[k*N +: N] = N'(k + 1);
    return r;
  endfunction

  function automatic logic [EW-1:0] alt_pat(input logic [N-1:0] ev, input logic [N-1:0] od);
    logic [EW-1:0] r;
    for (int k = 0; k < TN; k++) r[k*N +: N] = (k % 2 == 0) ? ev : od;
    return r;
  endfunction

  // Cluster model: 0 = lane k gives k+1, 1 = psum+1, 2 = max (5 then max(psum,3)),
  // 3 = even lanes FFF0 / odd lanes 0007.
  function automatic logic [EW-1:0] cluster(input int mode, input int pass, input logic [EW-1:0] psum);
    logic [EW-1:0] r;
    logic [N-1:0]  p;
    r = '0;
    for (int k = 0; k < TN; k++) begin
      p = psum[k*N +: N];
      case (mode)
        0:       r[k*N +: N] = N'(k + 1);
        1:       r[k*N +: N] = p + 16'd1;
        2:       r[k*N +: N] = (pass == 0) ? 16'd5 : ((p > 16'd3) ? p : 16'd3);
        default: r[k*N +: N] = (k % 2 == 0) ? 16'hFFF0 : 16'h0007;
      endcase
    end
    return r;
  endfunction

  // Start a tile and run all steps, checking the partial sum at every stage-out.
  task automatic run_accum(input string name, input int iters, input logic op, input int mode,
                           input logic step_with_start, input logic extra_step);
    int eff;
    int total;
    int e;
    int p;
    logic [EW-1:0] exp_ps;
    i_start = 1'b1;
    i_iters = ITW'(iters);
    i_op    = op;
    i_step  = step_with_start;
    i_res   = '1;
    cycle();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_op !== op) begin
      errors++;
      $display("FAIL %s_start: busy=%b op=%b expected busy=1 op=%b", name, o_busy, o_op, op);
    end
    eff   = (iters == 0) ? 1 : iters;
    total = DEPTH * eff;
    for (int s = 0; s <= total; s++) begin
      i_step  = (s < total) || extra_step;
      i_start = (s == 1);   // ignored outside IDLE
      if (s >= 1) begin
        e = (s - 1) % DEPTH;
        p = (s - 1) / DEPTH;
        exp_ps = (p == 0) ? '0 : model[e];
      end else begin
        e = 0;
        p = 0;
        exp_ps = '0;
      end
      checks++;
      if (o_partial_sum !== exp_ps) begin
        errors++;
        $display("FAIL %s_psum s=%0d: got %h expected %h", name, s, o_partial_sum, exp_ps);
      end
      if (s >= 1) begin
        i_res    = cluster(mode, p, o_partial_sum);
        model[e] = i_res;
      end else begin
        i_res = '1;
      end
      cycle();
    end
    i_step  = 1'b0;
    i_start = 1'b0;
    i_res   = '1;
  endtask

  task automatic run_drain(input string name, input logic [EW-1:0] exp_d [DEPTH],
                           input int stall_beat, input int stall_n);
    for (int b = 0; b < DEPTH; b++) begin
      if (b == stall_beat) begin
        drain_if.out_ready = 1'b0;
        for (int c = 0; c < stall_n; c++) begin
          checks++;
          if (drain_if.out_valid !== 1'b1 || drain_if.out_idx !== IDX_W'(b) ||
              drain_if.out_data !== exp_d[b]) begin
            errors++;
            $display("FAIL %s_stall b=%0d: valid=%b idx=%0d data=%h expected valid=1 idx=%0d data=%h",
                     name, b, drain_if.out_valid, drain_if.out_idx, drain_if.out_data, b, exp_d[b]);
          end
          cycle();
        end
      end
      drain_if.out_ready = 1'b1;
      checks++;
      if (drain_if.out_valid !== 1'b1 || drain_if.out_idx !== IDX_W'(b) ||
          drain_if.out_data !== exp_d[b] || o_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_beat b=%0d: valid=%b idx=%0d done=%b data=%h expected valid=1 idx=%0d done=0 data=%h",
                 name, b, drain_if.out_valid, drain_if.out_idx, o_done, drain_if.out_data, b, exp_d[b]);
      end
      $display("%s drain beat idx=%0d data=%h", name, drain_if.out_idx, drain_if.out_data);
      cycle();
    end
    checks++;
    if (drain_if.out_valid !== 1'b0 || o_done !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: valid=%b done=%b busy=%b expected 0 1 0",
               name, drain_if.out_valid, o_done, o_busy);
    end
    cycle();
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b expected 0", name, o_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_start = 1'b0;
    i_iters = '0;
    i_op = 1'b0;
    i_step = 1'b0;
    i_res = '0;
    drain_if.out_ready = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || drain_if.out_valid !== 1'b0 ||
        o_op !== 1'b0 || o_partial_sum !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b valid=%b op=%b psum=%h expected all 0",
               o_busy, o_done, drain_if.out_valid, o_op, o_partial_sum);
    end
    $display("reset: busy=%b valid=%b", o_busy, drain_if.out_valid);
  endtask

  // iters=1 sum; i_step raised with i_start must be ignored
  task automatic test_single_pass();
    logic [EW-1:0] exp_d [DEPTH];
    for (int b = 0; b < DEPTH; b++) exp_d[b] = lanes_inc();
    run_accum("single", 1, 1'b0, 0, 1'b1, 1'b0);
    run_drain("single", exp_d, -1, 0);
  endtask

  // iters=3 sum with psum+1; an extra step after the final one is ignored
  task automatic test_multi_pass_sum();
    logic [EW-1:0] exp_d [DEPTH];
    for (int b = 0; b < DEPTH; b++) exp_d[b] = fill(16'd3);
    run_accum("sum3", 3, 1'b0, 1, 1'b0, 1'b1);
    run_drain("sum3", exp_d, -1, 0);
  endtask

  task automatic test_max();
    logic [EW-1:0] exp_d [DEPTH];
    for (int b = 0; b < DEPTH; b++) exp_d[b] = fill(16'd5);
    run_accum("max2", 2, 1'b1, 2, 1'b0, 1'b0);
    run_drain("max2", exp_d, -1, 0);
  endtask

  task automatic test_mid_reset();
    i_start = 1'b1;
    i_iters = ITW'(3);
    i_op    = 1'b1;
    cycle();
    i_start = 1'b0;
    i_step  = 1'b1;
    i_res   = fill(16'd9);
    repeat (6) cycle();
    // head now holds step 5 = entry 1 on pass 1, whose stored value is all 9s
    checks++;
    if (o_partial_sum !== fill(16'd9) || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: psum=%h busy=%b expected %h busy=1", o_partial_sum, o_busy, fill(16'd9));
    end
    i_step = 1'b0;
    rst    = 1'b1;
    cycle();
    rst    = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_partial_sum !== '0 || o_op !== 1'b0 ||
        drain_if.out_valid !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: busy=%b psum=%h op=%b valid=%b done=%b expected all 0",
               o_busy, o_partial_sum, o_op, drain_if.out_valid, o_done);
    end
    $display("midrst: busy=%b", o_busy);
    // stray step in IDLE has no effect
    i_step = 1'b1;
    cycle();
    i_step = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_partial_sum !== '0) begin
      errors++;
      $display("FAIL idle_step: busy=%b psum=%h expected busy=0 psum=0", o_busy, o_partial_sum);
    end
  endtask

  // clean tile after reset, with ready low for 3 cycles at beat 1
  task automatic test_stall();
    logic [EW-1:0] exp_d [DEPTH];
    for (int b = 0; b < DEPTH; b++) exp_d[b] = lanes_inc();
    run_accum("stall", 0, 1'b0, 0, 1'b0, 1'b0);
    run_drain("stall", exp_d, 1, 3);
  endtask

  task automatic test_relu();
    logic [EW-1:0] exp_d [DEPTH];
    for (int b = 0; b < DEPTH; b++) begin
`ifdef NBOUT_RELU_EN
      exp_d[b] = alt_pat(16'h0000, 16'h0007);
`else
      exp_d[b] = alt_pat(16'hFFF0, 16'h0007);
`endif
    end
    run_accum("relu_sum", 1, 1'b0, 3, 1'b0, 1'b0);
    run_drain("relu_sum", exp_d, -1, 0);
    for (int b = 0; b < DEPTH; b++) exp_d[b] = alt_pat(16'hFFF0, 16'h0007);
    run_accum("relu_max", 1, 1'b1, 3, 1'b0, 1'b0);
    run_drain("relu_max", exp_d, -1, 0);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass_sum();
    test_max();
    test_mid_reset();
    test_stall();
    test_relu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
